// File: rtl/rv32im_muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package rv32im_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  localparam int unsigned ITERS = 32;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input md_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/rv32im_muldiv_iter.sv
// One iteration of the sequential datapath: shift-add multiply or restoring divide.
module rv32im_muldiv_iter
  import rv32im_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next_c
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // acc = {hi, lo}: product {partial, multiplier} or divide {remainder, quotient}
  always_comb begin
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
    shifted    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge         = shifted >= {1'b0, opnd};
    diff       = shifted[WIDTH-1:0] - opnd;
    acc_next_c = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (ge) begin
        acc_next_c = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_c = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/rv32im_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide with sign fix-up.
module rv32im_muldiv
  import rv32im_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_md_op,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_result_ack,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(ITERS);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  md_op_e             op_q, op_d;
  logic               neg_q, neg_d;

  md_op_e             op_in;
  logic               signed_a, signed_b, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               b_zero, sovf;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, result;

  rv32im_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div     (is_div_op(op_q)),
    .acc        (acc_q),
    .opnd       (opnd_q),
    .acc_next_c (step_acc)
  );

  // Request decode: operand signedness, magnitudes and bypass conditions
  always_comb begin
    op_in    = md_op_e'(i_md_op);
    signed_a = (op_in != OP_MULHU) && (op_in != OP_DIVU) && (op_in != OP_REMU);
    signed_b = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sign_a   = signed_a && i_rs1_data[WIDTH-1];
    sign_b   = signed_b && i_rs2_data[WIDTH-1];
    mag_a    = sign_a ? -i_rs1_data : i_rs1_data;
    mag_b    = sign_b ? -i_rs2_data : i_rs2_data;
    b_zero   = (i_rs2_data == '0);
    sovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (i_rs1_data == {1'b1, (WIDTH-1)'(0)}) && (i_rs2_data == '1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state: flush wins over everything; bypass cases jump straight to DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_d  = op_in;
            cnt_d = '0;
            if (is_div_op(op_in)) begin
              if (b_zero) begin
                acc_d   = {mag_a, {WIDTH{1'b1}}};
                neg_d   = is_rem_op(op_in) && sign_a;
                state_d = S_DONE;
              end else if (sovf) begin
                acc_d   = {(WIDTH)'(0), 1'b1, (WIDTH-1)'(0)};
                neg_d   = 1'b0;
                state_d = S_DONE;
              end else begin
                acc_d   = {(WIDTH)'(0), mag_a};
                opnd_d  = mag_b;
                neg_d   = is_rem_op(op_in) ? sign_a : (sign_a ^ sign_b);
                state_d = S_CALC;
              end
            end else begin
              acc_d   = {(WIDTH)'(0), mag_b};
              opnd_d  = mag_a;
              neg_d   = sign_a ^ sign_b;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS-1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (i_result_ack) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sign-corrected result, presented only while DONE
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    result   = '0;
    if (state_q == S_DONE) begin
      unique case (op_q)
        OP_MUL:                        result = prod_fix[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
        OP_DIV, OP_DIVU:               result = quot_fix;
        OP_REM, OP_REMU:               result = rem_fix;
        default:                       result = '0;
      endcase
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_busy   = (state_q == S_CALC) || (state_q == S_DONE);
  assign o_result = result;

endmodule
